z16_dmem_arbiter: RTL and testbench

//  Shares the single-port Z16 data memory between two requesters: port 0 (CPU load/store

---
 rtl/z16_pkg.sv | 16 +
 rtl/z16_arb_grant.sv | 76 +++++++
 rtl/z16_dmem_arbiter.sv | 89 ++++++++
 tb/tb_z16_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z16_pkg.sv
// Shared types and widths for the Z16 data-memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package z16_pkg;

  localparam int Z16_ADDR_W = 16;
  localparam int Z16_DATA_W = 16;

  // Which requester owns the load whose data returns next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/z16_arb_grant.sv
// Two-way combinational grant with port-1 starvation bound (or round-robin).
// Latency: grant is combinational in the request cycle; internal state updates on the clock.
// Backpressure: a denied requester simply holds its request; grants are forced low in reset.
// Optional feature macro: Z16_ARB_ROUND_ROBIN_EN (alternate contended cycles instead).
module z16_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_m0_req,
  input  logic i_m1_req,
  output logic o_m0_gnt,
  output logic o_m1_gnt
);

  logic w_m1_wins;

`ifdef Z16_ARB_ROUND_ROBIN_EN
  // 1 = port 1 won the last contended cycle; reset value lets port 0 win first
  logic r_last;

  // Port 1 wins a contended cycle only if port 0 won the previous one
  always_comb begin
    w_m1_wins = !r_last;
  end

  // Remember the winner of each contended cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_m0_req && i_m1_req) begin
      r_last <= w_m1_wins;
    end
  end
`else
  localparam int                WAIT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

  // Consecutive cycles port 1 has been requesting without a grant
  logic [WAIT_W-1:0] r_wait;

  // Port 1 overrides port 0 once it has waited the full bound
  always_comb begin
    w_m1_wins = (r_wait == WAIT_MAX);
  end

  // Count denied port-1 cycles, saturating; any grant or idle cycle clears it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait <= '0;
    end else if (i_m1_req && !o_m1_gnt) begin
      if (r_wait != WAIT_MAX) begin
        r_wait <= r_wait + 1'b1;
      end
    end else begin
      r_wait <= '0;
    end
  end
`endif

  // At most one grant; a lone requester is always granted
  always_comb begin
    o_m0_gnt = 1'b0;
    o_m1_gnt = 1'b0;
    if (!i_rst) begin
      if (i_m0_req && i_m1_req) begin
        o_m1_gnt = w_m1_wins;
        o_m0_gnt = !w_m1_wins;
      end else begin
        o_m0_gnt = i_m0_req;
        o_m1_gnt = i_m1_req;
      end
    end
  end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Shares the single-port Z16 data memory between the CPU (port 0) and a secondary master (port 1).
// Latency: access issued in the grant cycle; load data returns exactly one cycle later.
// Backpressure: a denied port holds req/we/addr/wdata until gnt; port-1 wait is bounded.
// Optional feature macro: Z16_ARB_ROUND_ROBIN_EN (handled inside z16_arb_grant).
module z16_dmem_arbiter
  import z16_pkg::*;
#(
  parameter int ADDR_W     = Z16_ADDR_W,
  parameter int DATA_W     = Z16_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic   w_m0_gnt;
  logic   w_m1_gnt;
  owner_e r_rd_owner;

  z16_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_m0_req (i_m0_req),
    .i_m1_req (i_m1_req),
    .o_m0_gnt (w_m0_gnt),
    .o_m1_gnt (w_m1_gnt)
  );

  assign o_m0_gnt = w_m0_gnt;
  assign o_m1_gnt = w_m1_gnt;

  // Steer the granted port onto the memory; idle bus is driven to zero
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    if (w_m0_gnt) begin
      o_mem_addr  = i_m0_addr;
      o_mem_wdata = i_m0_wdata;
      o_mem_we    = i_m0_we;
    end else if (w_m1_gnt) begin
      o_mem_addr  = i_m1_addr;
      o_mem_wdata = i_m1_wdata;
      o_mem_we    = i_m1_we;
    end
  end

  // Record which port issued a granted load so its data can be routed back next cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_owner <= OWN_NONE;
    end else if (w_m0_gnt && !i_m0_we) begin
      r_rd_owner <= OWN_M0;
    end else if (w_m1_gnt && !i_m1_we) begin
      r_rd_owner <= OWN_M1;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  // Route returning data to its owner only; reset suppresses a return already in flight
  always_comb begin
    o_m0_rvalid = (r_rd_owner == OWN_M0) && !i_rst;
    o_m1_rvalid = (r_rd_owner == OWN_M1) && !i_rst;
    o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
    o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Scoreboard bench for z16_dmem_arbiter: directed scenarios followed by random traffic.
// Expected grants come from a per-cycle arbitration model; expected load data from a model memory.
// A negedge monitor pops expected read returns / memory writes as the DUT presents them.
module tb_z16_dmem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
  logic [15:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid, o_mem_we;
  logic [15:0] o_m0_rdata, o_m1_rdata, o_mem_addr, o_mem_wdata;
  logic [15:0] i_mem_rdata = 16'h0;

  z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int cyc; logic [15:0] dat; } rd_item_t;
  typedef struct { int cyc; logic [15:0] adr; logic [15:0] dat; } wr_item_t;

  rd_item_t exp_rd0[$];
  rd_item_t exp_rd1[$];
  wr_item_t exp_wr[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference arbitration state: consecutive denied port-1 cycles / whose turn it is
  int m1_streak = 0;
  bit m0_turn   = 1'b1;

  bit [15:0] ref_mem [256];
  bit [15:0] env_mem [256];
  bit        env_wr  [256];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, a ^ 8'h5A};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // Environment memory: single port, read data valid the cycle after the address
  always @(posedge i_clk) begin
    if (o_mem_we) begin
      env_mem[o_mem_addr[7:0]] <= o_mem_wdata;
      env_wr[o_mem_addr[7:0]]  <= 1'b1;
    end
    i_mem_rdata <= env_wr[o_mem_addr[7:0]] ? env_mem[o_mem_addr[7:0]] : init_val(o_mem_addr[7:0]);
  end

  // Monitor: pop and compare whenever the DUT presents a read return or a memory write
  always @(negedge i_clk) begin
    rd_item_t r;
    wr_item_t w;
    if (o_m0_rvalid) begin
      if (exp_rd0.size() == 0) chk("m0_rvalid_unexpected", 32'(o_m0_rvalid), 32'd0);
      else begin
        r = exp_rd0.pop_front();
        chk("m0_rvalid_cycle", cyc, r.cyc);
        chk("m0_rdata", 32'(o_m0_rdata), 32'(r.dat));
      end
    end else begin
      if (exp_rd0.size() > 0 && exp_rd0[0].cyc <= cyc) begin
        chk("m0_rvalid_missing", 32'(o_m0_rvalid), 32'd1);
        void'(exp_rd0.pop_front());
      end
      chk("m0_rdata_idle", 32'(o_m0_rdata), 32'd0);
    end
    if (o_m1_rvalid) begin
      if (exp_rd1.size() == 0) chk("m1_rvalid_unexpected", 32'(o_m1_rvalid), 32'd0);
      else begin
        r = exp_rd1.pop_front();
        chk("m1_rvalid_cycle", cyc, r.cyc);
        chk("m1_rdata", 32'(o_m1_rdata), 32'(r.dat));
      end
    end else begin
      if (exp_rd1.size() > 0 && exp_rd1[0].cyc <= cyc) begin
        chk("m1_rvalid_missing", 32'(o_m1_rvalid), 32'd1);
        void'(exp_rd1.pop_front());
      end
      chk("m1_rdata_idle", 32'(o_m1_rdata), 32'd0);
    end
    if (o_mem_we) begin
      if (exp_wr.size() == 0) chk("mem_we_unexpected", 32'(o_mem_we), 32'd0);
      else begin
        w = exp_wr.pop_front();
        chk("mem_we_cycle", cyc, w.cyc);
        chk("mem_wr_addr", 32'(o_mem_addr), 32'(w.adr));
        chk("mem_wr_data", 32'(o_mem_wdata), 32'(w.dat));
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
      chk("mem_we_missing", 32'(o_mem_we), 32'd1);
      void'(exp_wr.pop_front());
    end
  end

  // One clock cycle of stimulus: drive, compare grants against the model, push expectations.
  // Returns the DUT's grants so requesters can follow the hold-until-granted handshake.
  task automatic drive_cycle(
    input bit rst,
    input bit m0r, input bit m0we, input logic [15:0] m0a, input logic [15:0] m0d,
    input bit m1r, input bit m1we, input logic [15:0] m1a, input logic [15:0] m1d,
    output bit g0, output bit g1);
    bit e0, e1;
    @(posedge i_clk);
    #1;
    i_rst = rst;
    i_m0_req = m0r; i_m0_we = m0we; i_m0_addr = m0a; i_m0_wdata = m0d;
    i_m1_req = m1r; i_m1_we = m1we; i_m1_addr = m1a; i_m1_wdata = m1d;
    if (rst) begin
      // a load granted last cycle must not return once reset is asserted
      exp_rd0.delete();
      exp_rd1.delete();
    end
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst) begin
      m1_streak = 0;
      m0_turn   = 1'b1;
      chk("rst_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
      chk("rst_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
    end else begin
`ifdef Z16_ARB_ROUND_ROBIN_EN
      if (m0r && m1r) begin
        e0 = m0_turn;
        e1 = !m0_turn;
        m0_turn = !m0_turn;
      end else begin
        e0 = m0r;
        e1 = m1r;
      end
`else
      if (m0r && m1r) begin
        e1 = (m1_streak >= STARVE_MAX);
        e0 = !e1;
      end else begin
        e0 = m0r;
        e1 = m1r;
      end
      m1_streak = (m1r && !e1) ? m1_streak + 1 : 0;
`endif
    end
    chk("m0_gnt", 32'(o_m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(o_m1_gnt), 32'(e1));
    if (!e0 && !e1) begin
      chk("idle_mem_we", 32'(o_mem_we), 32'd0);
      chk("idle_mem_addr", 32'(o_mem_addr), 32'd0);
      chk("idle_mem_wdata", 32'(o_mem_wdata), 32'd0);
    end
    if (e0) begin
      if (m0we) begin
        ref_mem[m0a[7:0]] = m0d;
        exp_wr.push_back('{cyc, m0a, m0d});
      end else exp_rd0.push_back('{cyc + 1, ref_mem[m0a[7:0]]});
    end
    if (e1) begin
      if (m1we) begin
        ref_mem[m1a[7:0]] = m1d;
        exp_wr.push_back('{cyc, m1a, m1d});
      end else exp_rd1.push_back('{cyc + 1, ref_mem[m1a[7:0]]});
    end
    g0 = o_m0_gnt;
    g1 = o_m1_gnt;
  endtask

  initial begin
    bit g0, g1, exp1;
    bit p0, p0we, p1, p1we, rst;
    logic [15:0] p0a, p0d, p1a, p1d;
    i_rst = 1'b1;
    i_m0_req = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_wdata = '0;
    i_m1_req = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    // reset: outputs quiet even with requests present
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0, g0, g1);

    // 1: lone CPU load of 0x0010 returns 0xBEEF next cycle
    drive_cycle(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, g0, g1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // 2 / 6: both requesting continuously
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 1, 0, 16'(8'h20 + i), 0, 1, 0, 16'h0030, 0, g0, g1);
`ifdef Z16_ARB_ROUND_ROBIN_EN
      exp1 = (i % 2 == 1);
`else
      exp1 = (i % 5 == STARVE_MAX);
`endif
      chk("contend_m1_pattern", 32'(g1), 32'(exp1));
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // 3: CPU store to 0x007A against a port-1 load of the same address
    drive_cycle(0, 1, 1, 16'h007A, 16'h002A, 1, 0, 16'h007A, 0, g0, g1);
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 16'h007A, 0, g0, g1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // 4: alternating single-port loads every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive_cycle(0, 1, 0, 16'(i), 0, 0, 0, 0, 0, g0, g1);
      else            drive_cycle(0, 0, 0, 0, 0, 1, 0, 16'(i + 8), 0, g0, g1);
    end

    // 5: build up port-1 wait, then reset the cycle after a granted load
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 0, 16'h0040, 0, 1, 0, 16'h0041, 0, g0, g1);
    drive_cycle(1, 1, 0, 16'h0040, 0, 1, 0, 16'h0041, 0, g0, g1);
    drive_cycle(0, 1, 0, 16'h0040, 0, 1, 0, 16'h0041, 0, g0, g1);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    // random traffic with hold-until-granted requesters and occasional resets
    p0 = 0; p1 = 0; p0we = 0; p1we = 0; p0a = '0; p0d = '0; p1a = '0; p1d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1; p0we = 1'($urandom_range(0, 1));
        p0a = 16'($urandom_range(0, 31)); p0d = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < 50) begin
        p1 = 1; p1we = 1'($urandom_range(0, 1));
        p1a = 16'($urandom_range(0, 31)); p1d = 16'($urandom);
      end
      rst = ($urandom_range(0, 99) < 2);
      drive_cycle(rst, p0, p0we, p0a, p0d, p1, p1we, p1a, p1d, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end

    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("drain_rd0", exp_rd0.size(), 0);
    chk("drain_rd1", exp_rd1.size(), 0);
    chk("drain_wr", exp_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
